fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the RISC-V core, directly upstream of the decoder and the immediate extender. It owns the program counter and issues word fetches to instruction memory with one request outstanding at most. It buffers responses through a one-entry skid buffer and presents instructions to decode on a valid/ready handshake. It accepts PC redirects from the branch/jump resolution logic, which computes them from the extended immediate.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC of the first fetch after reset.
- `NOP_INSTR`, default `32'h0000_0013`: value driven on `instr` when nothing valid is presented (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: single-cycle fetch request pulse. Memory always accepts it.
- `imem_addr` out 32: word address of the request. Bits [1:0] are always 00.
- `imem_rvalid` in 1: response valid. Arrives 1 or more cycles after `imem_req`.
- `imem_rdata` in 32: response instruction word.
- `instr_valid` out 1: the instruction on `instr` is valid.
- `instr_ready` in 1: decode accepts the instruction this cycle.
- `instr` out 32: instruction to decoder and extender.
- `instr_pc` out 32: PC of `instr`.
- `instr_pc4` out 32: `instr_pc + 4`, modulo 2^32.
- `redirect_valid` in 1: redirect the fetch stream.
- `redirect_pc` in 32: new fetch PC.
- `fetch_misaligned` out 1: misaligned redirect flag. Present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- Registers: `fetch_pc`, `outstanding`, `stale`, output slot (`instr_valid`, `instr`, `instr_pc`), skid slot (`skid_valid`, `skid_instr`, `skid_pc`).
- Issue rule: `imem_req` = !rst && !`outstanding` && (!`skid_valid` || slot drains this cycle) && !`redirect_valid` && !HALT. Then `imem_addr` = `fetch_pc`.
- On issue: `outstanding`←1. The issued PC is remembered as `req_pc`. `fetch_pc`←`fetch_pc`+4 (wraps at 2^32).
- Response with `stale`=0:
  - If the output slot is empty, or `instr_ready`=1, load it into the output slot.
  - Otherwise load it into the skid slot.
  - In both cases `outstanding`←0.
- Response with `stale`=1: discard it; clear `stale` and `outstanding`.
- Drain: when `instr_valid`&&`instr_ready`, the output slot takes the skid contents if `skid_valid`, otherwise it takes the same-cycle response, otherwise it empties.
- Order is always preserved: skid first, then the new response.
- Redirect has priority over everything else in the same cycle:
  - Output and skid slots clear; `instr_valid`←0 next cycle.
  - `fetch_pc`←`redirect_pc`.
  - If a request is outstanding and no response arrives that cycle, `stale`←1.
  - A same-cycle response is discarded.
  - A same-cycle `instr_ready` handshake still counts as consumed.
- States: IDLE (after reset), RUN, HALT (macro only).
  - IDLE→RUN on the first cycle with `rst`=0; the first request issues in that cycle.
  - HALT issues no requests and leaves only on an aligned redirect.
- When `instr_valid`=0, `instr`=`NOP_INSTR`.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=`NOP_INSTR`, `instr_pc`=`RESET_PC`, `instr_pc4`=`RESET_PC`+4, `fetch_misaligned`=0, `outstanding`=`stale`=`skid_valid`=0.
- `rst` asserted mid-fetch: all state returns to reset values next edge. A later response to the pre-reset request arrives while `outstanding`=0 and is ignored.
- Latency: `imem_rvalid` at cycle N produces `instr_valid`=1 at N+1, provided the slot is free.
- With 1-cycle memory and `instr_ready` held high, throughput is one instruction every 2 cycles.
- After a redirect at cycle R with nothing outstanding: request at R+1, earliest `instr_valid` at R+3.
- `instr`, `instr_pc` and `instr_pc4` hold stable while `instr_valid`&&!`instr_ready`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 enters HALT.
  - `fetch_misaligned`=1 from the next cycle until an aligned redirect.
  - `instr_pc` reports the faulting `redirect_pc`.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - The port is absent.
  - `redirect_pc[1:0]` is forced to 00 and fetch continues.

## Test plan
- Reset release, 1-cycle memory returning `32'h00500093` at `0x0`:
  - `imem_req`@`0x0` in first cycle; `instr_valid`=1 with `instr_pc`=0 and `instr_pc4`=4 two cycles later.
- `instr_ready`=0 for 5 cycles while the stream runs:
  - Output slot and skid fill; `imem_req` stays 0 afterwards.
  - On release, instructions from `0x0`, `0x4`, `0x8` are delivered in order with no loss or duplicate.
- Redirect to `0x100` while a request to `0x8` is outstanding with 3-cycle latency:
  - The `0x8` response is dropped.
  - Next `imem_addr`=`0x100`; the first delivered `instr_pc`=`0x100`.
- Redirect coinciding with `imem_rvalid` and `instr_ready`:
  - Response discarded; `instr_valid`=0 next cycle; request to the redirect target the cycle after.
- `fetch_pc`=`0xFFFF_FFFC`:
  - `instr_pc4`=`0x0`; next `imem_addr`=`0x0`.
- Redirect to `0x102`:
  - With macro: HALT, `fetch_misaligned`=1, no requests until a redirect to `0x200`.
  - Without macro: next fetch at `0x100`.

Source files
------------

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Purpose  : Fetch-stage bus bundle: instruction memory, decode handshake and
//            redirect. fetch_misaligned exists only with FETCH_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
`ifdef FETCH_MISALIGN_TRAP_EN
        output fetch_misaligned,
`endif
        input  imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
`ifdef FETCH_MISALIGN_TRAP_EN
        input  fetch_misaligned,
`endif
        output imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RISC-V instruction fetch: PC, single outstanding imem request,
//            one-entry skid buffer, valid/ready to decode, redirects.
//            Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input wire       clk,
    input wire       rst,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_outstanding;
    logic        r_stale;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    logic        w_drain;
    logic        w_resp;
    logic        w_live;
    logic        w_halt;
    logic        w_issue;
    logic [31:0] w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        r_misaligned;
    logic        w_misaligned;
    assign w_misaligned          = |bus.redirect_pc[1:0];
    assign w_target              = bus.redirect_pc;
    assign bus.fetch_misaligned  = r_misaligned;
`else
    assign w_target              = bus.redirect_pc & ~32'h0000_0003;
`endif

    // Responses seen with nothing outstanding belong to a request killed by reset.
    assign w_drain = r_valid && bus.instr_ready;
    assign w_resp  = bus.imem_rvalid && r_outstanding;
    assign w_live  = w_resp && !r_stale;
    assign w_halt  = (r_state == S_HALT);
    assign w_issue = !rst && !r_outstanding && (!r_skid_valid || w_drain)
                     && !bus.redirect_valid && !w_halt;

    assign bus.imem_req    = w_issue;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = r_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_pc;
    assign bus.instr_pc4   = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_outstanding <= 1'b0;
            r_stale       <= 1'b0;
            r_valid       <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_pc          <= RESET_PC;
            r_skid_valid  <= 1'b0;
            r_skid_instr  <= NOP_INSTR;
            r_skid_pc     <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misaligned  <= 1'b0;
`endif
        end else begin
            if (r_state == S_IDLE) begin
                r_state <= S_RUN;
            end

            if (bus.redirect_valid) begin
                r_valid      <= 1'b0;
                r_instr      <= NOP_INSTR;
                r_skid_valid <= 1'b0;
                // An in-flight request is marked stale so its response is dropped.
                if (w_resp) begin
                    r_outstanding <= 1'b0;
                    r_stale       <= 1'b0;
                end else if (r_outstanding) begin
                    r_stale <= 1'b1;
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                if (w_misaligned) begin
                    r_state      <= S_HALT;
                    r_misaligned <= 1'b1;
                    r_pc         <= bus.redirect_pc;
                end else begin
                    r_state      <= S_RUN;
                    r_misaligned <= 1'b0;
                    r_fetch_pc   <= w_target;
                end
`else
                r_fetch_pc <= w_target;
`endif
            end else begin
                if (w_issue) begin
                    r_outstanding <= 1'b1;
                    r_req_pc      <= r_fetch_pc;
                    r_fetch_pc    <= r_fetch_pc + 32'd4;
                end
                if (w_resp) begin
                    r_outstanding <= 1'b0;
                    r_stale       <= 1'b0;
                end

                if (w_drain) begin
                    if (r_skid_valid) begin
                        r_instr      <= r_skid_instr;
                        r_pc         <= r_skid_pc;
                        r_skid_valid <= w_live;
                        if (w_live) begin
                            r_skid_instr <= bus.imem_rdata;
                            r_skid_pc    <= r_req_pc;
                        end
                    end else if (w_live) begin
                        r_instr <= bus.imem_rdata;
                        r_pc    <= r_req_pc;
                    end else begin
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                    end
                end else if (w_live) begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_instr <= bus.imem_rdata;
                        r_pc    <= r_req_pc;
                    end else begin
                        r_skid_valid <= 1'b1;
                        r_skid_instr <= bus.imem_rdata;
                        r_skid_pc    <= r_req_pc;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: memory responder, stream
//            model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic clk;
    logic rst;
    int   mem_lat;
    int   vectors;
    int   miscompares;

    fetch_if fif();

    fetch_unit #(
        .RESET_PC  (C_RESET_PC),
        .NOP_INSTR (C_NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, want);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, want);
        end
    endtask

    // Instruction memory: each request answers mem_lat cycles later with memf(addr).
    int          q_cnt[$];
    logic [31:0] q_addr[$];
    initial begin
        logic        hit;
        logic [31:0] a;
        fif.imem_rvalid = 1'b0;
        fif.imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            if (fif.imem_req === 1'b1) begin
                q_cnt.push_back(mem_lat);
                q_addr.push_back(fif.imem_addr);
            end
            foreach (q_cnt[i]) q_cnt[i] = q_cnt[i] - 1;
            hit = 1'b0;
            a   = 32'h0;
            if (q_cnt.size() > 0 && q_cnt[0] <= 0) begin
                hit = 1'b1;
                a   = q_addr[0];
                void'(q_cnt.pop_front());
                void'(q_addr.pop_front());
            end
            #1;
            fif.imem_rvalid = hit;
            fif.imem_rdata  = hit ? memf(a) : 32'hDEAD_BEEF;
        end
    end

    // Stream model: requests walk up from the last target, deliveries follow
    // the same sequence with no gaps or repeats; redirects restart both.
    logic [31:0] exp_fetch, exp_pc, prev_instr, prev_pc;
    bit          prev_hold, prev_redirect, m_out;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_fetch     = C_RESET_PC;
                exp_pc        = C_RESET_PC;
                prev_hold     = 1'b0;
                prev_redirect = 1'b0;
                m_out         = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk1 ("hold_valid", fif.instr_valid, 1'b1);
                    chk32("hold_instr", fif.instr, prev_instr);
                    chk32("hold_pc", fif.instr_pc, prev_pc);
                end
                if (prev_redirect) chk1("valid_after_redirect", fif.instr_valid, 1'b0);
                if (!fif.instr_valid) chk32("nop_when_idle", fif.instr, C_NOP);
                if (fif.imem_req) begin
                    chk1 ("single_outstanding", m_out, 1'b0);
                    chk32("req_addr", fif.imem_addr, exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
                if (fif.instr_valid && fif.instr_ready) begin
                    chk32("deliver_pc", fif.instr_pc, exp_pc);
                    chk32("deliver_instr", fif.instr, memf(exp_pc));
                    chk32("deliver_pc4", fif.instr_pc4, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                end
                if (fif.imem_rvalid) m_out = 1'b0;
                if (fif.imem_req)    m_out = 1'b1;
                if (fif.redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (fif.redirect_pc[1:0] == 2'b00) begin
                        exp_fetch = fif.redirect_pc;
                        exp_pc    = fif.redirect_pc;
                    end
`else
                    exp_fetch = {fif.redirect_pc[31:2], 2'b00};
                    exp_pc    = exp_fetch;
`endif
                end
                prev_hold     = fif.instr_valid && !fif.instr_ready && !fif.redirect_valid;
                prev_redirect = fif.redirect_valid;
                prev_instr    = fif.instr;
                prev_pc       = fif.instr_pc;
            end
        end
    end

    task automatic do_reset(input int lat, input logic rdy);
        @(posedge clk); #1;
        rst = 1'b1;
        fif.redirect_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mem_lat         = lat;
        fif.instr_ready = rdy;
        rst             = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] a, input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (fif.imem_req && fif.imem_addr == a) found = 1'b1;
        end
        chk1(name, found, 1'b1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (fif.instr_valid) found = 1'b1;
        end
        chk1(name, found, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat;
        int          hs;
        vectors            = 0;
        miscompares        = 0;
        rst                = 1'b1;
        mem_lat            = 1;
        fif.instr_ready    = 1'b1;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = 32'h0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1 ("rst_imem_req", fif.imem_req, 1'b0);
        chk32("rst_imem_addr", fif.imem_addr, C_RESET_PC);
        chk1 ("rst_instr_valid", fif.instr_valid, 1'b0);
        chk32("rst_instr", fif.instr, C_NOP);
        chk32("rst_instr_pc", fif.instr_pc, C_RESET_PC);
        chk32("rst_instr_pc4", fif.instr_pc4, 32'h4);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk1 ("rst_misaligned", fif.fetch_misaligned, 1'b0);
`endif

        // First fetch after reset release, 1-cycle memory
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk1 ("first_req", fif.imem_req, 1'b1);
                chk32("first_addr", fif.imem_addr, 32'h0);
            end
            if (k == 1) chk1("first_valid_early", fif.instr_valid, 1'b0);
            if (k == 2) begin
                chk1 ("first_valid", fif.instr_valid, 1'b1);
                chk32("first_pc", fif.instr_pc, 32'h0);
                chk32("first_pc4", fif.instr_pc4, 32'h4);
                chk32("first_instr", fif.instr, 32'h0050_0093);
                chk1 ("second_req", fif.imem_req, 1'b1);
                chk32("second_addr", fif.imem_addr, 32'h4);
            end
        end

        // Back-pressure: slot and skid fill, then drain in order
        do_reset(1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 2) chk32("bp_req4_addr", fif.imem_addr, 32'h4);
            if (k == 2) chk1 ("bp_req4", fif.imem_req, 1'b1);
            if (k >= 4) chk1 ("bp_no_req", fif.imem_req, 1'b0);
            if (k == 6) chk32("bp_slot_pc", fif.instr_pc, 32'h0);
        end
        @(posedge clk); #1;
        fif.instr_ready = 1'b1;
        @(negedge clk);
        chk32("bp_out0", fif.instr_pc, 32'h0);
        chk1 ("bp_req8", fif.imem_req, 1'b1);
        chk32("bp_req8_addr", fif.imem_addr, 32'h8);
        @(negedge clk);
        chk32("bp_out4", fif.instr_pc, 32'h4);
        @(negedge clk);
        chk32("bp_out8", fif.instr_pc, 32'h8);

        // Redirect while 0x8 is in flight with 3-cycle memory
        do_reset(3, 1'b1);
        wait_req(32'h8, 20, "lat3_req8");
        @(posedge clk); #1;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h100;
        @(negedge clk);
        chk1("redir_blocks_req", fif.imem_req, 1'b0);
        @(posedge clk); #1;
        fif.redirect_valid = 1'b0;
        @(negedge clk);
        chk1("stale_wait1", fif.imem_req, 1'b0);
        @(negedge clk);
        chk1("stale_wait2", fif.imem_req, 1'b0);
        wait_req(32'h100, 1, "redir_req100");
        wait_valid(10, "redir_valid_seen");
        chk32("redir_first_pc", fif.instr_pc, 32'h100);

        // Redirect coinciding with a response and a consumed handshake
        @(posedge clk); #1;
        mem_lat         = 1;
        fif.instr_ready = 1'b0;
        wait_req(32'h108, 10, "coinc_req108");
        @(posedge clk); #1;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h40;
        fif.instr_ready    = 1'b1;
        @(negedge clk);
        chk1 ("coinc_handshake", fif.instr_valid, 1'b1);
        chk32("coinc_consumed_pc", fif.instr_pc, 32'h104);
        @(posedge clk); #1;
        fif.redirect_valid = 1'b0;
        @(negedge clk);
        chk1 ("coinc_valid_cleared", fif.instr_valid, 1'b0);
        chk1 ("coinc_req", fif.imem_req, 1'b1);
        chk32("coinc_req_addr", fif.imem_addr, 32'h40);

        // PC wrap at the top of the address space
        @(posedge clk); #1;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        fif.redirect_valid = 1'b0;
        wait_valid(10, "wrap_valid_seen");
        chk32("wrap_pc", fif.instr_pc, 32'hFFFF_FFFC);
        chk32("wrap_pc4", fif.instr_pc4, 32'h0);
        chk1 ("wrap_req", fif.imem_req, 1'b1);
        chk32("wrap_req_addr", fif.imem_addr, 32'h0);

        // Misaligned redirect
        @(posedge clk); #1;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h102;
        @(posedge clk); #1;
        fif.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        @(negedge clk);
        chk1 ("mis_flag", fif.fetch_misaligned, 1'b1);
        chk32("mis_pc", fif.instr_pc, 32'h102);
        chk1 ("mis_valid", fif.instr_valid, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk1("mis_halt_no_req", fif.imem_req, 1'b0);
        end
        @(posedge clk); #1;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h200;
        @(posedge clk); #1;
        fif.redirect_valid = 1'b0;
        wait_req(32'h200, 5, "mis_resume_req200");
        chk1("mis_flag_clear", fif.fetch_misaligned, 1'b0);
`else
        wait_req(32'h100, 5, "mis_forced_align_req100");
`endif

        // Mixed ready pattern with 2-cycle memory and one redirect
        @(posedge clk); #1;
        mem_lat = 2;
        pat     = 16'b1101_0110_1110_0101;
        hs      = 0;
        for (int k = 0; k < 48; k++) begin
            fif.instr_ready    = pat[k % 16];
            fif.redirect_valid = (k == 20);
            fif.redirect_pc    = 32'h480;
            @(negedge clk);
            if (fif.instr_valid && fif.instr_ready) hs++;
            @(posedge clk); #1;
        end
        fif.redirect_valid = 1'b0;
        fif.instr_ready    = 1'b1;
        chk1("mixed_progress", hs >= 5, 1'b1);

        // Reset mid-fetch; the late response must be ignored
        mem_lat            = 3;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h300;
        @(posedge clk); #1;
        fif.redirect_valid = 1'b0;
        wait_req(32'h300, 12, "rstmid_req300");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1 ("rstmid_req", fif.imem_req, 1'b1);
        chk32("rstmid_addr", fif.imem_addr, C_RESET_PC);
        chk1 ("rstmid_valid", fif.instr_valid, 1'b0);
        wait_valid(10, "rstmid_valid_seen");
        chk32("rstmid_pc", fif.instr_pc, 32'h0);
        chk32("rstmid_instr", fif.instr, 32'h0050_0093);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
